instruction_fetch: RTL and testbench

- Fetch-side initiator for the 9-bit-instruction, 256-entry combinational instruction ROM.
- Holds the PC, drives the ROM address, and registers the returned word into an instruction register (IR) for decode.
- Handles start, stall, branch redirect with squash, and halt-opcode detection.
- Sits between the ROM and the decode/execute stage of the lab CPU.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/pc_counter.sv | 18 +
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 9;
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam logic [3:0] DEF_HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
endpackage

// File: rtl/pc_counter.sv
// PC register: load beats increment beats hold; increment wraps at 2^ADDR_W.
module pc_counter #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= load_value;
    else if (inc)  pc <= pc + ADDR_W'(1);
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: PC -> combinational ROM -> IR, with stall, branch squash and halt.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter logic [3:0] HALT_OPCODE = DEF_HALT_OPCODE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               halted,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_squashed
);
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_load_value;
  logic              halt_word;

  assign halt_word   = rom_instruction[OPC_HI:OPC_LO] == HALT_OPCODE;
  assign rom_address = pc;

  // start wins everywhere; branch only redirects while fetching; halt word freezes PC
  always_comb begin
    pc_load       = 1'b0;
    pc_load_value = RESET_PC;
    pc_inc        = 1'b0;
    if (start) begin
      pc_load = 1'b1;
    end else if (state == FETCH) begin
      if (branch_taken) begin
        pc_load       = 1'b1;
        pc_load_value = branch_target;
      end else if (!stall && !halt_word) begin
        pc_inc = 1'b1;
      end
    end
  end

  pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir_valid <= 1'b0;
      ir_instr <= '0;
      ir_pc    <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (start || branch_taken) begin
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir_instr <= rom_instruction;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (halt_word) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state    <= FETCH;
            halted   <= 1'b0;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_evt, squash_evt;
  assign fetch_evt  = (state == FETCH) && !start && !branch_taken && !stall;
  assign squash_evt = (state == FETCH) && !start && branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else if (start) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (fetch_evt && perf_fetched != 16'hFFFF)   perf_fetched  <= perf_fetched + 16'd1;
      if (squash_evt && perf_squashed != 16'hFFFF) perf_squashed <= perf_squashed + 16'd1;
    end
  end
`else
  assign perf_fetched  = '0;
  assign perf_squashed = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural reference model.
module tb_instruction_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [7:0] branch_target = '0;
  logic [7:0] rom_address;
  logic [8:0] rom_instruction;
  logic       ir_valid, halted;
  logic [8:0] ir_instr;
  logic [7:0] ir_pc;
  logic [15:0] perf_fetched, perf_squashed;

  logic [8:0] rom [256];
  assign rom_instruction = rom[rom_address];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_address(rom_address),
    .rom_instruction(rom_instruction), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ir_valid(ir_valid), .ir_instr(ir_instr),
    .ir_pc(ir_pc), .halted(halted), .perf_fetched(perf_fetched),
    .perf_squashed(perf_squashed)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = running, 2 = halted
  int         m_mode = 0;
  int         m_pc = 0;
  bit         m_valid = 0, m_halted = 0;
  logic [8:0] m_instr = '0;
  int         m_irpc = 0;
  int         m_fet = 0, m_sq = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_halted = 0;
      m_instr = '0; m_irpc = 0; m_fet = 0; m_sq = 0;
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_valid = 0; m_halted = 0; m_fet = 0; m_sq = 0;
    end else if (m_mode == 1) begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_valid = 0;
        if (m_sq < 65535) m_sq++;
      end else if (!stall) begin
        logic [8:0] w;
        w = rom[m_pc];
        m_instr = w; m_irpc = m_pc; m_valid = 1;
        if (m_fet < 65535) m_fet++;
        if (w[8:5] == 4'b1111) begin
          m_mode = 2; m_halted = 1;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else if (m_mode == 2) begin
      if (!stall) m_valid = 0;
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    check("m_rom_address", 32'(rom_address), 32'(m_pc));
    check("m_ir_valid", 32'(ir_valid), 32'(m_valid));
    check("m_halted", 32'(halted), 32'(m_halted));
    if (m_valid) begin
      check("m_ir_instr", 32'(ir_instr), 32'(m_instr));
      check("m_ir_pc", 32'(ir_pc), 32'(m_irpc));
    end
`ifdef FETCH_PERF_CNT_EN
    check("m_perf_fetched", 32'(perf_fetched), 32'(m_fet));
    check("m_perf_squashed", 32'(perf_squashed), 32'(m_sq));
`else
    check("m_perf_fetched", 32'(perf_fetched), 32'd0);
    check("m_perf_squashed", 32'(perf_squashed), 32'd0);
`endif
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {1'b0, 8'(a)};
    rom[0] = 9'h14F; rom[1] = 9'h16F; rom[2] = 9'h0B1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("reset_ir_valid", 32'(ir_valid), 0);
    check("reset_ir_instr", 32'(ir_instr), 0);
    check("reset_ir_pc", 32'(ir_pc), 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_rom_address", 32'(rom_address), 0);
    rst_n = 1'b1;
    tick();

    // start: no IR load in the start cycle
    start = 1'b1; tick(); start = 1'b0;
    check("start_no_load", 32'(ir_valid), 0);
    tick();
    check("first_valid", 32'(ir_valid), 1);
    check("first_instr", 32'(ir_instr), 32'h14F);
    check("first_pc", 32'(ir_pc), 0);
    tick();
    check("second_instr", 32'(ir_instr), 32'h16F);

    // stall three cycles at ir_pc=1
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", 32'(ir_instr), 32'h16F);
      check("stall_pc", 32'(ir_pc), 1);
      check("stall_addr", 32'(rom_address), 2);
    end
    stall = 1'b0;
    tick();
    check("resume_pc", 32'(ir_pc), 2);
    check("resume_instr", 32'(ir_instr), 32'h0B1);
    tick(); tick();
    check("pre_branch_addr", 32'(rom_address), 5);

    // branch at PC=5 to 0x40
    branch_taken = 1'b1; branch_target = 8'h40; tick(); branch_taken = 1'b0;
    check("branch_bubble", 32'(ir_valid), 0);
    check("branch_addr", 32'(rom_address), 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check("branch_squashed", 32'(perf_squashed), 1);
`endif
    tick();
    check("branch_target_pc", 32'(ir_pc), 32'h40);
    check("branch_target_valid", 32'(ir_valid), 1);

    // wrap 255 -> 0
    branch_taken = 1'b1; branch_target = 8'hFE; tick(); branch_taken = 1'b0;
    tick(); tick();
    check("wrap_255", 32'(ir_pc), 255);
    tick();
    check("wrap_0", 32'(ir_pc), 0);

    // asynchronous reset pulse mid-fetch
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ir_valid), 0);
    check("async_addr", 32'(rom_address), 0);
    check("async_pc", 32'(ir_pc), 0);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_fetch", 32'(ir_valid), 0);
    check("idle_addr", 32'(rom_address), 0);

    // halt program: word 1111_00000 at address 3
    rom[3] = 9'h1E0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("halt_valid", 32'(ir_valid), 1);
    check("halt_instr", 32'(ir_instr), 32'h1E0);
    check("halt_flag", 32'(halted), 1);
    check("halt_addr", 32'(rom_address), 3);
    branch_taken = 1'b1; branch_target = 8'h80; tick(); branch_taken = 1'b0;
    check("halt_drop_valid", 32'(ir_valid), 0);
    check("halt_ignore_branch", 32'(rom_address), 3);
    tick();
    check("halt_still", 32'(halted), 1);

    // restart from HALT, start overriding branch, then halt under stall
    start = 1'b1; tick(); start = 1'b0;
    check("restart_halted", 32'(halted), 0);
    check("restart_addr", 32'(rom_address), 0);
    tick();
    start = 1'b1; branch_taken = 1'b1; branch_target = 8'h77; tick();
    start = 1'b0; branch_taken = 1'b0;
    check("start_over_branch_addr", 32'(rom_address), 0);
    check("start_over_branch_valid", 32'(ir_valid), 0);
    repeat (4) tick();
    check("halt2_flag", 32'(halted), 1);
    stall = 1'b1; tick();
    check("halt_stall_hold", 32'(ir_valid), 1);
    stall = 1'b0; tick();
    check("halt_stall_release", 32'(ir_valid), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
